spmv_x_gather: RTL
==================

// Module: spmv_x_gather
// PURPOSE
//  Gathers dense-vector elements x[col] for the SpMV kernel. Consumes a stream of {col_idx, nz_val, row_last}
//  tuples and issues one single-beat 32-bit AXI read per tuple on its master port.
//  That master port connects directly to the slave side of the narrow-to-burst read aggregator, which returns data in order.
//  Emits the in-order stream {x_val, nz_val, row_last} to the multiply-accumulate stage.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  48  AXI address width
//  C_M_AXI_ID_WIDTH    1   AXI ID width; arid is driven to 0
//  C_DATA_WIDTH        32  width of x_val / nz_val / rdata
//  C_IDX_WIDTH         32  column index width
//  C_DEPTH             16  max in-flight tuples (power of 2, >=2); sets credit count and FIFO depths
// PORTS
//  clk            in   1      clock
//  rstn           in   1      asynchronous active-low reset
//  x_base_addr    in   ADDR   byte base address of x; sampled at each tuple accept
//  in_col_idx     in   IDX    column index
//  in_nz_val      in   DATA   matrix nonzero value (side-band)
//  in_row_last    in   1      last nonzero of the row (side-band)
//  in_valid       in   1      tuple valid
//  in_ready       out  1      tuple accepted when in_valid & in_ready
//  m_axi_arid     out  ID     constant 0
//  m_axi_araddr   out  ADDR   read address
//  m_axi_arlen    out  8      constant 0
//  m_axi_arsize   out  3      constant 3'b010
//  m_axi_arburst  out  2      constant 2'b01
//  m_axi_arvalid  out  1      read request valid
//  m_axi_arready  in   1      read request ready
//  m_axi_rdata    in   DATA   read data
//  m_axi_rresp    in   2      read response
//  m_axi_rlast    in   1      expected 1 on every beat
//  m_axi_rvalid   in   1      read data valid
//  m_axi_rready   out  1      read data ready
//  out_x_val      out  DATA   gathered x[col]
//  out_nz_val     out  DATA   matching nonzero
//  out_row_last   out  1      matching row_last
//  out_valid      out  1      output valid
//  out_ready      in   1      output ready
//  err            out  1      sticky: rresp!=0 or rlast==0 was seen
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - arvalid=0, araddr=0, out_valid=0, err=0.
//   - Credits=C_DEPTH; both FIFOs empty; m_axi_rready=1.
//   - On deassert, all in-flight state is discarded. A mid-operation reset drops outstanding reads.
//     Upstream is responsible for draining the aggregator.
//  Credits:
//   - credit = C_DEPTH - (issued-not-returned + returned-not-consumed).
//   - Decrement on tuple accept, increment on output handshake.
//   - Same-cycle accept and output handshake leaves credit unchanged.
//  Accept: in_ready = (credit!=0) & (~m_axi_arvalid | m_axi_arready). No combinational path from in_valid to in_ready.
//  On accept, next cycle:
//   - m_axi_arvalid=1.
//   - m_axi_araddr = x_base_addr + (in_col_idx << 2), truncated to ADDR bits (wraps modulo 2^ADDR).
//   - {nz_val,row_last} pushed to the side FIFO.
//  AR handshake: arvalid and araddr hold stable until arready. Back-to-back accepts issue one AR per cycle.
//  R channel:
//   - m_axi_rready stays 1 after reset; credit guarantees data-FIFO space.
//   - Each rvalid beat pushes rdata into the data FIFO.
//   - rresp!=0 or rlast==0 sets err. The data is still pushed; ordering is never broken.
//  Output:
//   - out_valid = data FIFO and side FIFO both non-empty (FWFT).
//   - Fields come from the FIFO heads. Handshake pops both FIFOs.
//   - Latency from R beat to out_valid is 1 cycle. Minimum accept-to-out_valid is 2 cycles plus AR/R latency.
//  Boundaries:
//   - credit==0 -> in_ready=0; the AR of the last accepted tuple still completes.
//   - FIFO pointers wrap modulo C_DEPTH.
//   - Simultaneous push and pop on a full or empty FIFO is legal and preserves occupancy.
//   - out_ready=0 indefinitely stalls intake once credits are exhausted; no data is lost.
// TESTING
//  T1 single: base=0x1000, col=5, nz=0xA -> araddr=0x1014, arlen=0; rdata=0x55 -> out {0x55,0xA,last} once.
//  T2 credit stall: C_DEPTH=16, out_ready=0, 20 tuples offered -> exactly 16 ARs, in_ready=0.
//     Then out_ready=1 -> the remaining 4 issue and all 20 outputs arrive in order.
//  T3 AR backpressure: arready low 5 cycles -> araddr/arvalid stable; no tuple lost or duplicated.
//  T4 streaming: continuous in_valid, arready=1, R returned 3 cycles after AR, out_ready=1 -> 1 tuple/cycle sustained.
//  T5 wrap/error: base=0xFFFF_FFFF_FFFC, col=2 -> araddr=0x4; rresp=2 -> err=1, output still delivered.
//  T6 reset mid-flight: assert rstn=0 with 8 outstanding -> arvalid=0, out_valid=0, credit=16 immediately.

Source files
------------

// File: rtl/spmv_x_gather.sv
// SpMV x-vector gather: one single-beat AXI read per {col, nz, row_last} tuple,
// re-joined in order with the side-band fields for the multiply-accumulate stage.
module spmv_x_gather #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 48,
  parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_DATA_WIDTH       = 32,
  parameter int unsigned C_IDX_WIDTH        = 32,
  parameter int unsigned C_DEPTH            = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] x_base_addr,
  input  logic [C_IDX_WIDTH-1:0]        in_col_idx,
  input  logic [C_DATA_WIDTH-1:0]       in_nz_val,
  input  logic                          in_row_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [C_DATA_WIDTH-1:0]       out_x_val,
  output logic [C_DATA_WIDTH-1:0]       out_nz_val,
  output logic                          out_row_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          err
);

  localparam int unsigned PtrW  = $clog2(C_DEPTH);
  localparam int unsigned CredW = PtrW + 1;
  localparam int unsigned SideW = C_DATA_WIDTH + 1;
  localparam logic [PtrW:0] PtrOne = 1;
  localparam logic [CredW-1:0] CredOne = 1;

  logic                          arvalid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d, col_off;
  logic [CredW-1:0]              credit_q, credit_d;
  logic                          err_q;
  logic                          accept, out_fire, r_push;

  logic [SideW-1:0]        side_mem [C_DEPTH];
  logic [C_DATA_WIDTH-1:0] data_mem [C_DEPTH];
  logic [PtrW:0]           side_wr_q, side_rd_q, data_wr_q, data_rd_q;
  logic                    side_empty, data_empty;

  // in_ready never looks at in_valid; arready only frees the single AR slot.
  assign in_ready = (credit_q != '0) & (~arvalid_q | m_axi_arready);
  assign accept   = in_valid & in_ready;
  assign r_push   = m_axi_rvalid;

  assign col_off  = C_M_AXI_ADDR_WIDTH'(in_col_idx) << 2;
  assign araddr_d = x_base_addr + col_off;

  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_rready  = 1'b1;
  assign err           = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
    end else if (accept) begin
      arvalid_q <= 1'b1;
      araddr_q  <= araddr_d;
    end else if (m_axi_arready) begin
      arvalid_q <= 1'b0;
    end
  end

  always_comb begin
    credit_d = credit_q;
    if (accept && !out_fire) begin
      credit_d = credit_q - CredOne;
    end else if (!accept && out_fire) begin
      credit_d = credit_q + CredOne;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_q <= CredW'(C_DEPTH);
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      if (r_push && ((m_axi_rresp != 2'b00) || !m_axi_rlast)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Credits bound occupancy of both FIFOs, so pushes never need a full check.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      side_wr_q <= '0;
      side_rd_q <= '0;
      data_wr_q <= '0;
      data_rd_q <= '0;
    end else begin
      if (accept) side_wr_q <= side_wr_q + PtrOne;
      if (r_push) data_wr_q <= data_wr_q + PtrOne;
      if (out_fire) begin
        side_rd_q <= side_rd_q + PtrOne;
        data_rd_q <= data_rd_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) side_mem[side_wr_q[PtrW-1:0]] <= {in_nz_val, in_row_last};
    if (r_push) data_mem[data_wr_q[PtrW-1:0]] <= m_axi_rdata;
  end

  assign side_empty = (side_wr_q == side_rd_q);
  assign data_empty = (data_wr_q == data_rd_q);
  assign out_valid  = ~side_empty & ~data_empty;
  assign out_fire   = out_valid & out_ready;

  assign {out_nz_val, out_row_last} = side_mem[side_rd_q[PtrW-1:0]];
  assign out_x_val                  = data_mem[data_rd_q[PtrW-1:0]];

endmodule
